// File: rtl/dot_matrix_pkg.sv
// Shared types, defaults and PWM helper for the dot-matrix scanner.
// Optional PWM dimming is enabled with `define DOTMATRIX_PWM_EN.
package dot_matrix_pkg;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  localparam int DEF_COLS  = 16;
  localparam int DEF_ROWS  = 16;
  localparam int DEF_DWELL = 1000;
  localparam int DEF_BLANK = 4;

  // Number of lit cycles per dwell for a 4-bit brightness level.
  function automatic int pwm_thr(
    input logic [3:0] b,
    input int         dwell
  );
    return ((int'(b) + 1) * dwell) >> 4;
  endfunction

endpackage

// File: rtl/dot_matrix_frame_buf.sv
// Double-buffered column store: back buffer written, front buffer read.
// Optional PWM dimming is enabled with `define DOTMATRIX_PWM_EN (not used here).
module dot_matrix_frame_buf #(
  parameter int COLS  = 4,
  parameter int ROWS  = 8,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  logic [ROWS-1:0]  wdata,
  input  logic             toggle,
  input  logic [COL_W-1:0] raddr,
  output logic [ROWS-1:0]  rdata,
  output logic             sel
);

  logic [ROWS-1:0] mem [2][COLS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++)
          mem[b][c] <= '0;
      sel <= 1'b0;
    end else begin
      // Write uses the pre-toggle select, so a write in the swap cycle
      // lands in the buffer that is about to become the front.
      if (we && (int'(waddr) < COLS))
        mem[~sel][waddr] <= wdata;
      if (toggle)
        sel <= ~sel;
    end
  end

  assign rdata = mem[sel][raddr];

endmodule

// File: rtl/dot_matrix_scanner.sv
// Double-buffered LED dot-matrix column scanner with blanking.
// Optional PWM dimming is enabled with `define DOTMATRIX_PWM_EN.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter  int COLS  = DEF_COLS,
  parameter  int ROWS  = DEF_ROWS,
  parameter  int DWELL = DEF_DWELL,
  parameter  int BLANK = DEF_BLANK,
  localparam int COL_W = $clog2(COLS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_CLR,
  input  logic             LOAD,
  input  logic [COL_W-1:0] load_addr,
  input  logic [ROWS-1:0]  in_column,
  input  logic             SWAP,
`ifdef DOTMATRIX_PWM_EN
  input  logic [3:0]       brightness,
`endif
  output logic [COL_W-1:0] column_seg,
  output logic [ROWS-1:0]  out_column,
  output logic             COLUMN_CLK,
  output logic             OUT_CLR,
  output logic             frame_sync,
  output logic             swap_pending
);

  localparam int CMAX  = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W = $clog2(CMAX) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROWS-1:0]  front_col;
  logic             front_sel;
  logic             end_blank;
  logic             end_show;
  logic             wrap;
  logic             toggle;
  logic             lit_first;
  logic             lit_next;
  logic [COL_W-1:0] next_col;

  assign end_blank = (state == S_BLANK)
                  && (cnt == CNT_W'(BLANK - 1));
  assign end_show  = (state == S_SHOW)
                  && (cnt == CNT_W'(DWELL - 1));
  assign wrap      = end_show
                  && (column_seg == COL_W'(COLS - 1));
  assign toggle    = wrap && swap_pending && !IN_CLR;
  assign next_col  = (column_seg == COL_W'(COLS - 1))
                   ? '0 : column_seg + 1'b1;

`ifdef DOTMATRIX_PWM_EN
  logic [3:0] bright_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      bright_q <= 4'hF;
    else if (wrap && !IN_CLR)
      bright_q <= brightness;
  end

  // Gating is evaluated for the cycle being registered, i.e. cnt+1.
  assign lit_first = 0 < pwm_thr(bright_q, DWELL);
  assign lit_next  = (int'(cnt) + 1) < pwm_thr(bright_q, DWELL);
`else
  assign lit_first = 1'b1;
  assign lit_next  = 1'b1;
`endif

  dot_matrix_frame_buf #(
    .COLS (COLS),
    .ROWS (ROWS),
    .COL_W(COL_W)
  ) u_buf (
    .clk   (CLK),
    .rst   (RESET),
    .we    (LOAD),
    .waddr (load_addr),
    .wdata (in_column),
    .toggle(toggle),
    .raddr (column_seg),
    .rdata (front_col),
    .sel   (front_sel)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= S_BLANK;
      cnt          <= '0;
      column_seg   <= '0;
      out_column   <= '0;
      COLUMN_CLK   <= 1'b0;
      OUT_CLR      <= 1'b1;
      frame_sync   <= 1'b0;
      swap_pending <= 1'b0;
    end else if (IN_CLR) begin
      state        <= S_BLANK;
      cnt          <= '0;
      column_seg   <= '0;
      out_column   <= '0;
      COLUMN_CLK   <= 1'b0;
      OUT_CLR      <= 1'b1;
      frame_sync   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      COLUMN_CLK <= 1'b0;
      frame_sync <= 1'b0;
      unique case (state)
        S_BLANK: begin
          if (end_blank) begin
            state      <= S_SHOW;
            cnt        <= '0;
            OUT_CLR    <= 1'b0;
            out_column <= lit_first ? front_col : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (end_show) begin
            state      <= S_BLANK;
            cnt        <= '0;
            column_seg <= next_col;
            COLUMN_CLK <= 1'b1;
            frame_sync <= wrap;
            OUT_CLR    <= 1'b1;
            out_column <= '0;
          end else begin
            cnt        <= cnt + 1'b1;
            out_column <= lit_next ? front_col : '0;
          end
        end
        default: state <= S_BLANK;
      endcase
      if (toggle)
        swap_pending <= 1'b0;
      else if (SWAP)
        swap_pending <= 1'b1;
    end
  end

  logic unused_sel;
  assign unused_sel = front_sel;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Randomized bench for dot_matrix_scanner against a frame-time model.
// Optional PWM dimming is enabled with `define DOTMATRIX_PWM_EN.
module tb_dot_matrix_scanner;

  localparam int COLS  = 4;
  localparam int ROWS  = 8;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = COLS * SLOT;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_CLR = 1'b0;
  logic       LOAD = 1'b0;
  logic [1:0] load_addr = '0;
  logic [7:0] in_column = '0;
  logic       SWAP = 1'b0;
`ifdef DOTMATRIX_PWM_EN
  logic [3:0] brightness = 4'hF;
`endif
  logic [1:0] column_seg;
  logic [7:0] out_column;
  logic       COLUMN_CLK;
  logic       OUT_CLR;
  logic       frame_sync;
  logic       swap_pending;

  dot_matrix_scanner #(
    .COLS (COLS),
    .ROWS (ROWS),
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN_CLR      (IN_CLR),
    .LOAD        (LOAD),
    .load_addr   (load_addr),
    .in_column   (in_column),
    .SWAP        (SWAP),
`ifdef DOTMATRIX_PWM_EN
    .brightness  (brightness),
`endif
    .column_seg  (column_seg),
    .out_column  (out_column),
    .COLUMN_CLK  (COLUMN_CLK),
    .OUT_CLR     (OUT_CLR),
    .frame_sync  (frame_sync),
    .swap_pending(swap_pending)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: time since last restart, two buffers, front select, pending.
  int         t;
  int         fsel;
  bit         pend;
  logic [7:0] mbuf [2][COLS];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)",
                  tag, got, exp, t);
  endtask

  task automatic model_reset();
    t = 0;
    fsel = 0;
    pend = 0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < COLS; c++)
        mbuf[b][c] = '0;
  endtask

  task automatic model_edge();
    if (RESET) begin
      model_reset();
    end else begin
      if (LOAD && int'(load_addr) < COLS)
        mbuf[1 - fsel][load_addr] = in_column;
      if (IN_CLR) begin
        t = 0;
        pend = 0;
      end else begin
        t++;
        if (t % FRAME == 0 && pend) begin
          fsel = 1 - fsel;
          pend = 0;
        end else if (SWAP) begin
          pend = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int pos;
    int col;
    logic [7:0] e_out;
    pos = t % SLOT;
    col = (t / SLOT) % COLS;
    e_out = (pos < BLANK) ? 8'h00 : mbuf[fsel][col];
    check("column_seg", 32'(column_seg), 32'(col));
    check("out_column", 32'(out_column), 32'(e_out));
    check("COLUMN_CLK", 32'(COLUMN_CLK),
          32'(t > 0 && pos == 0));
    check("OUT_CLR", 32'(OUT_CLR), 32'(pos < BLANK));
    check("frame_sync", 32'(frame_sync),
          32'(t > 0 && t % FRAME == 0));
    check("swap_pending", 32'(swap_pending), 32'(pend));
  endtask

  task automatic step(input logic ld, input logic [1:0] a,
                      input logic [7:0] d, input logic sw,
                      input logic clr);
    LOAD = ld;
    load_addr = a;
    in_column = d;
    SWAP = sw;
    IN_CLR = clr;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    LOAD = 1'b0;
    SWAP = 1'b0;
    IN_CLR = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(3) == 0,
           2'($urandom_range(3)),
           8'($urandom),
           $urandom_range(15) == 0,
           $urandom_range(149) == 0);
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    step(1'b1, 2'd1, 8'hFF, 1'b1, 1'b0);
    check_outputs();
    RESET = 1'b0;
    idle(90);
    step(1'b1, 2'd1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(100);
    while ((t + 1) % FRAME != 0) idle(1);
    step(1'b1, 2'd2, 8'h3C, 1'b1, 1'b0);
    idle(90);
    while (!((t / SLOT) % COLS == 2 && t % SLOT == 5)) idle(1);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1);
    idle(50);
    rand_steps(1500);
    RESET = 1'b1;
    model_reset();
    #1;
    check_outputs();
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    RESET = 1'b0;
    idle(45);
    rand_steps(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
